// File: rtl/mem_access_unit_if.sv
// Word-addressed data-memory bus between the load/store unit and memory.
// The unit raises mem_req and holds the request fields stable until the
// memory answers with mem_ready; read data is sampled on that same cycle.
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit. Turns the M-stage access into one request on
// the word-addressed memory bus, stalls the pipeline until it completes,
// extends load data and flags misaligned/illegal accesses and bus timeouts.
module mem_access_unit #(
    parameter int unsigned DATA_WIDTH = 32,   // only 32 is supported
    parameter int unsigned TIMEOUT    = 255   // 0 disables the timeout
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic                  MemWriteM,
    input  logic                  MemReadM,
    input  logic [2:0]            funct3M,
    mem_access_unit_if.master     bus,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  MisalignM,
    output logic                  BusErrM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t state, state_nxt;

    // Decoded view of the M-stage access.
    logic                  acc;
    logic                  is_store;
    logic [1:0]            off;
    logic                  illegal;
    logic [3:0]            be_calc;
    logic [DATA_WIDTH-1:0] wdata_calc;

    // Access captured on entry to REQ, held stable until the memory answers.
    logic                  we_q;
    logic [31:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            be_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;

    logic [CNT_W-1:0]      wait_cnt;
    logic                  timeout_hit;
    logic                  req_c;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    assign acc      = MemReadM | MemWriteM;
    assign is_store = MemWriteM;              // store wins when both are set
    assign off      = ALUResultM[1:0];

    // The next missing-ready cycle would be the TIMEOUT-th one: abort now.
    assign timeout_hit = (TIMEOUT != 0) && !bus.mem_ready &&
                         (32'(wait_cnt) + 32'd1 == TIMEOUT);

    assign bus.mem_req   = req_c;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;

    // Legality check, byte enables and lane-replicated store data.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case leaves a value held and no latch is inferred.
        illegal    = 1'b0;
        be_calc    = 4'b0000;
        wdata_calc = '0;
        case (funct3M[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << off;
                wdata_calc = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_calc    = off[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{WriteDataM[15:0]}};
                illegal    = off[0];
            end
            2'b10: begin
                be_calc    = 4'b1111;
                wdata_calc = WriteDataM;
                illegal    = (off != 2'b00) | funct3M[2];
            end
            default: illegal = 1'b1;
        endcase
    end

    // Select the addressed lane of the returned word and extend it.
    always_comb begin
        load_ext = bus.mem_rdata;
        half_sel = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (off_q)
            2'd0:    byte_sel = bus.mem_rdata[7:0];
            2'd1:    byte_sel = bus.mem_rdata[15:8];
            2'd2:    byte_sel = bus.mem_rdata[23:16];
            default: byte_sel = bus.mem_rdata[31:24];
        endcase
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake/stall outputs.
    always_comb begin
        state_nxt = state;
        StallM    = 1'b0;
        req_c     = 1'b0;
        case (state)
            IDLE: begin
                if (acc && !illegal) begin
                    StallM    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                req_c  = 1'b1;
                StallM = 1'b1;
                if (bus.mem_ready || timeout_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, wait counter, load result and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            wait_cnt  <= '0;
            ReadDataM <= '0;
            MisalignM <= 1'b0;
            BusErrM   <= 1'b0;
        end else begin
            MisalignM <= (state == IDLE) && acc && illegal;
            BusErrM   <= (state == REQ) && timeout_hit;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (acc && !illegal) begin
                        we_q    <= is_store;
                        addr_q  <= {ALUResultM[31:2], 2'b00};
                        be_q    <= be_calc;
                        wdata_q <= is_store ? wdata_calc : '0;
                        f3_q    <= funct3M;
                        off_q   <= off;
                    end
                end
                REQ: begin
                    if (bus.mem_ready || timeout_hit) begin
                        // Request fields return to zero once the bus is idle.
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        be_q    <= '0;
                        if (bus.mem_ready && !we_q) ReadDataM <= load_ext;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed accesses from the test
// plan followed by random accesses, compared against a reference model
// derived from access size, alignment and memory-response delay.
module tb_mem_access_unit;

    localparam int unsigned TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM;
    logic        MemWriteM, MemReadM;
    logic [2:0]  funct3M;
    logic        StallM, MisalignM, BusErrM;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_rd = 32'd0;

    mem_access_unit_if bus();

    mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .funct3M    (funct3M),
        .bus        (bus),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Access width in bytes from funct3, 0 for an undefined encoding.
    function automatic int access_bytes(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        if (f3 == 3'b010) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] word, input int off,
                                           input int bytes, input bit sgn);
        longint v, span;
        if (bytes == 4) return word;
        span = longint'(1) << (8 * bytes);
        v = longint'(word >> (8 * off)) % span;
        if (sgn && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    task automatic idle_inputs();
        MemReadM      = 1'b0;
        MemWriteM     = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    // Presents one instruction at a negedge, acts as memory answering after
    // `delay` wait cycles, and lets the instruction leave M when StallM is low.
    // Returns at a negedge with the pipeline idle.
    task automatic run_access(input string name, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic rd, input logic wr,
                              input int delay, input logic [31:0] rdata);
        int   bytes, off, exp_req, stall_n, req_n, err_n;
        bit   legal, timed_out, left;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;

        bytes     = access_bytes(f3);
        off       = int'(addr[1:0]);
        legal     = (bytes != 0) && (off % (bytes == 0 ? 1 : bytes) == 0);
        timed_out = legal && (delay >= int'(TB_TIMEOUT));
        exp_req   = !legal ? 0 : (timed_out ? int'(TB_TIMEOUT) : delay + 1);
        exp_be    = 4'(((1 << bytes) - 1) << off);
        exp_wd    = (bytes == 1) ? wd[7:0] * 32'h01010101 :
                    (bytes == 2) ? wd[15:0] * 32'h00010001 : wd;
        if (legal && !wr && !timed_out) model_rd = extend(rdata, off, bytes, !f3[2]);

        ALUResultM    = addr;
        WriteDataM    = wd;
        funct3M       = f3;
        MemReadM      = rd;
        MemWriteM     = wr;
        bus.mem_rdata = rdata;
        bus.mem_ready = 1'b0;
        stall_n = 0; req_n = 0; err_n = 0; left = 1'b0;

        for (int c = 0; c < 40 && !left; c++) begin
            #1;
            if (bus.mem_req) begin
                check({name, "/addr"}, bus.mem_addr, {addr[31:2], 2'b00});
                check({name, "/be"}, 32'(bus.mem_be), 32'(exp_be));
                check({name, "/we"}, 32'(bus.mem_we), 32'(wr));
                if (wr) check({name, "/wdata"}, bus.mem_wdata, exp_wd);
                bus.mem_ready = (req_n >= delay);
                req_n++;
            end else begin
                bus.mem_ready = 1'b0;
            end
            if (BusErrM) err_n++;
            if (StallM) stall_n++;
            else        left = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        if (!left) check({name, "/left_stage"}, 32'd0, 32'd1);

        idle_inputs();
        #1;
        check({name, "/stall_cycles"}, 32'(stall_n), 32'(legal ? exp_req + 1 : 0));
        check({name, "/req_cycles"}, 32'(req_n), 32'(exp_req));
        check({name, "/buserr"}, 32'(err_n), 32'(timed_out));
        check({name, "/misalign"}, 32'(MisalignM), 32'(!legal));
        check({name, "/readdata"}, ReadDataM, model_rd);
        check({name, "/idle_req"}, 32'(bus.mem_req), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check({name, "/misalign_once"}, 32'(MisalignM), 32'd0);
    endtask

    initial begin
        logic [2:0] f3_tab [8];
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110};

        rst = 1'b1;
        ALUResultM = '0; WriteDataM = '0; funct3M = '0;
        bus.mem_rdata = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset/mem_req", 32'(bus.mem_req), 32'd0);
        check("reset/mem_we", 32'(bus.mem_we), 32'd0);
        check("reset/mem_addr", bus.mem_addr, 32'd0);
        check("reset/mem_wdata", bus.mem_wdata, 32'd0);
        check("reset/mem_be", 32'(bus.mem_be), 32'd0);
        check("reset/readdata", ReadDataM, 32'd0);
        check("reset/stall", 32'(StallM), 32'd0);
        check("reset/flags", {30'd0, MisalignM, BusErrM}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_access("sw", 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 0, 32'h0);
        run_access("lb", 3'b000, 32'h203, 32'h0, 1'b1, 1'b0, 0, 32'h80FF1234);
        check("lb/value", ReadDataM, 32'hFFFFFF80);
        run_access("lbu", 3'b100, 32'h203, 32'h0, 1'b1, 1'b0, 0, 32'h80FF1234);
        check("lbu/value", ReadDataM, 32'h00000080);
        run_access("lh", 3'b001, 32'h102, 32'h0, 1'b1, 1'b0, 0, 32'h9ABC0000);
        check("lh/value", ReadDataM, 32'hFFFF9ABC);
        run_access("sh", 3'b001, 32'h102, 32'h00005678, 1'b0, 1'b1, 0, 32'h0);
        run_access("lw_mis", 3'b010, 32'h101, 32'h0, 1'b1, 1'b0, 0, 32'h11111111);
        run_access("f3_011", 3'b011, 32'h100, 32'h0, 1'b1, 1'b0, 0, 32'h22222222);
        check("illegal/value", ReadDataM, 32'hFFFF9ABC);
        run_access("lw_tmo", 3'b010, 32'h300, 32'h0, 1'b1, 1'b0, 10, 32'h33333333);
        run_access("lw_wait2", 3'b010, 32'h304, 32'h0, 1'b1, 1'b0, 2, 32'h44556677);
        check("lw_wait2/value", ReadDataM, 32'h44556677);
        run_access("both", 3'b010, 32'h308, 32'hCAFEF00D, 1'b1, 1'b1, 1, 32'h55555555);

        // Reset in the middle of an outstanding request.
        ALUResultM = 32'h40; funct3M = 3'b010; MemReadM = 1'b1; MemWriteM = 1'b0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h66666666;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_mid/req_seen", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        #1;
        model_rd = 32'd0;
        check("rst_mid/mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mid/stall", 32'(StallM), 32'd0);
        check("rst_mid/bus", {bus.mem_be, 27'd0, bus.mem_we}, 32'd0);
        check("rst_mid/addr", bus.mem_addr, 32'd0);
        check("rst_mid/readdata", ReadDataM, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_access("sb_after_rst", 3'b000, 32'h1, 32'hAB, 1'b0, 1'b1, 0, 32'h0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, w, r;
            logic        rd, wr;
            int          kind;
            a    = $urandom;
            w    = $urandom;
            r    = $urandom;
            kind = int'($urandom_range(0, 2));
            rd   = (kind != 1);
            wr   = (kind != 0);
            run_access("rand", f3_tab[$urandom_range(0, 7)], a, w, rd, wr,
                       int'($urandom_range(0, 5)), r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
